// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
//
// Boot-time program loader that sits directly behind the UART instruction
// receiver. Each received 16-bit word is written sequentially into
// instruction memory starting at address 0. The CPU is held in reset while
// loading and is released once an end-of-program marker has been seen.
// A reload request discards the current program and re-arms the loader.
//
// Parameters
//   ADDR_WIDTH   : instruction memory address width (capacity 2^ADDR_WIDTH)
//   END_MARKER   : word that terminates a load; never written to memory
//
// Ports
//   clk            in   system clock, rising edge
//   rst            in   asynchronous active-high reset
//   i_rx_dv        in   one-cycle strobe, i_rx_instr valid while high
//   i_rx_instr     in   received 16-bit instruction word
//   i_reload       in   one-cycle request to restart loading
//   o_mem_we       out  instruction memory write enable (one cycle per word)
//   o_mem_addr     out  write address
//   o_mem_data     out  write data
//   o_cpu_rst      out  high holds the CPU in reset
//   o_load_done    out  high once a load has completed successfully
//   o_instr_count  out  words written during the current load
//   o_overflow     out  sticky flag: program exceeded memory capacity
// -----------------------------------------------------------------------------
module instr_loader #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [15:0] END_MARKER = 16'hFFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_rx_dv,
    input  logic [15:0]           i_rx_instr,
    input  logic                  i_reload,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [15:0]           o_mem_data,
    output logic                  o_cpu_rst,
    output logic                  o_load_done,
    output logic [ADDR_WIDTH:0]   o_instr_count,
    output logic                  o_overflow
);

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2,
        ST_ERROR   = 2'd3
    } state_t;

    // Count value meaning "memory completely filled".
    localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [15:0]           r_mem_data;
    logic                  r_cpu_rst;
    logic                  r_load_done;
    logic                  r_overflow;

    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] w_ptr_nxt;
    logic [ADDR_WIDTH:0]   w_count_nxt;
    logic                  w_mem_we_nxt;
    logic [ADDR_WIDTH-1:0] w_mem_addr_nxt;
    logic [15:0]           w_mem_data_nxt;
    logic                  w_cpu_rst_nxt;
    logic                  w_load_done_nxt;
    logic                  w_overflow_nxt;
    logic                  w_is_marker;
    logic                  w_full;

    assign w_is_marker = (i_rx_instr == END_MARKER);
    assign w_full      = (r_count == CAPACITY);

    // Next-state, pointer/count and write-port decode.
    always_comb begin
        w_next_state   = r_state;
        w_ptr_nxt      = r_ptr;
        w_count_nxt    = r_count;
        w_mem_we_nxt   = 1'b0;
        // Address and data hold their last written values between writes.
        w_mem_addr_nxt = r_mem_addr;
        w_mem_data_nxt = r_mem_data;

        if (i_reload) begin
            // Reload wins over a coincident strobe; that word is dropped.
            w_next_state = ST_LOAD;
            w_ptr_nxt    = {ADDR_WIDTH{1'b0}};
            w_count_nxt  = {(ADDR_WIDTH+1){1'b0}};
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (i_rx_dv) begin
                        if (w_is_marker) begin
                            w_next_state = ST_RELEASE;
                        end else if (w_full) begin
                            w_next_state = ST_ERROR;
                        end else begin
                            w_mem_we_nxt   = 1'b1;
                            w_mem_addr_nxt = r_ptr;
                            w_mem_data_nxt = i_rx_instr;
                            // Pointer wraps naturally; count is one bit wider
                            // so it reaches CAPACITY without wrapping.
                            w_ptr_nxt      = r_ptr + ADDR_WIDTH'(1);
                            w_count_nxt    = r_count + (ADDR_WIDTH+1)'(1);
                        end
                    end else begin
                        w_next_state = ST_LOAD;
                    end
                end
                // One-cycle gap keeps the CPU in reset at least two cycles
                // after the final memory write.
                ST_RELEASE: w_next_state = ST_RUN;
                ST_RUN:     w_next_state = ST_RUN;
                ST_ERROR:   w_next_state = ST_ERROR;
                default:    w_next_state = ST_LOAD;
            endcase
        end
    end

    // Status outputs are a pure function of the state being entered, so the
    // registered flags line up with the registered state.
    always_comb begin
        w_cpu_rst_nxt   = 1'b1;
        w_load_done_nxt = 1'b0;
        w_overflow_nxt  = 1'b0;
        case (w_next_state)
            ST_LOAD: begin
                w_cpu_rst_nxt   = 1'b1;
                w_load_done_nxt = 1'b0;
                w_overflow_nxt  = 1'b0;
            end
            ST_RELEASE: begin
                w_cpu_rst_nxt   = 1'b1;
                w_load_done_nxt = 1'b1;
                w_overflow_nxt  = 1'b0;
            end
            ST_RUN: begin
                w_cpu_rst_nxt   = 1'b0;
                w_load_done_nxt = 1'b1;
                w_overflow_nxt  = 1'b0;
            end
            ST_ERROR: begin
                w_cpu_rst_nxt   = 1'b1;
                w_load_done_nxt = 1'b0;
                w_overflow_nxt  = 1'b1;
            end
            default: begin
                w_cpu_rst_nxt   = 1'b1;
                w_load_done_nxt = 1'b0;
                w_overflow_nxt  = 1'b0;
            end
        endcase
    end

    // State, pointer and count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_LOAD;
            r_ptr   <= {ADDR_WIDTH{1'b0}};
            r_count <= {(ADDR_WIDTH+1){1'b0}};
        end else begin
            r_state <= w_next_state;
            r_ptr   <= w_ptr_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Registered memory write port and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {ADDR_WIDTH{1'b0}};
            r_mem_data  <= 16'h0000;
            r_cpu_rst   <= 1'b1;
            r_load_done <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_data  <= w_mem_data_nxt;
            r_cpu_rst   <= w_cpu_rst_nxt;
            r_load_done <= w_load_done_nxt;
            r_overflow  <= w_overflow_nxt;
        end
    end

    assign o_mem_we      = r_mem_we;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_data    = r_mem_data;
    assign o_cpu_rst     = r_cpu_rst;
    assign o_load_done   = r_load_done;
    assign o_instr_count = r_count;
    assign o_overflow    = r_overflow;

endmodule
